// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NUM_CH capture FIFOs into one SRAM write port.
// Define ARB_URGENT_PRIO_EN to let almost-full channels jump the queue.
module fifo_drain_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 17,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_empty,
  input  logic [NUM_CH-1:0]         ch_almost_full,
  input  logic [NUM_CH*WIDTH-1:0]   ch_data,
  output logic [NUM_CH-1:0]         ch_read_en,
  output logic                      sram_req,
  input  logic                      sram_ack,
  output logic [WIDTH-1:0]          sram_wdata,
  output logic [$clog2(NUM_CH)-1:0] sram_ch,
  output logic                      sram_last,
  output logic                      busy
);

  localparam int CW = $clog2(NUM_CH);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    CAPTURE,
    ISSUE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   last_grant_q, last_grant_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            last_q, last_d;

  logic [CW-1:0]   pick;
  logic [CW-1:0]   cand;
  logic            found;
  logic [BW-1:0]   beat_inc;

`ifdef ARB_URGENT_PRIO_EN
  logic            urg_found;
`else
  logic            unused_af;
  assign unused_af = ^ch_almost_full;
`endif

  // Search order starts just after the previous burst's owner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CW'((int'(last_grant_q) + k) % NUM_CH);
      if (!found && !ch_empty[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
`ifdef ARB_URGENT_PRIO_EN
    urg_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!urg_found && !ch_empty[i] && ch_almost_full[i]) begin
        urg_found = 1'b1;
        pick      = CW'(i);
      end
    end
`endif
  end

  assign beat_inc = beat_q + BW'(1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    wdata_d      = wdata_q;
    ch_d         = ch_q;
    last_d       = last_q;
    ch_read_en   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = POP;
        end
      end
      POP: begin
        ch_read_en[grant_q] = 1'b1;
        state_d             = CAPTURE;
      end
      CAPTURE: begin
        wdata_d = ch_data[int'(grant_q)*WIDTH +: WIDTH];
        ch_d    = grant_q;
        beat_d  = beat_inc;
        last_d  = (beat_inc == BW'(BURST_LEN)) || ch_empty[grant_q];
        state_d = ISSUE;
      end
      ISSUE: begin
        if (sram_ack) begin
          if (last_q) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            state_d = POP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(NUM_CH - 1);
      beat_q       <= '0;
      wdata_q      <= '0;
      ch_q         <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      wdata_q      <= wdata_d;
      ch_q         <= ch_d;
      last_q       <= last_d;
    end
  end

  assign sram_req   = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign sram_wdata = wdata_q;
  assign sram_ch    = ch_q;
  assign sram_last  = last_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: FIFO models feed the DUT, a scoreboard
// holds the words expected on the SRAM port in arbitration order.
module tb_fifo_drain_arbiter;

  localparam int NCH = 4;
  localparam int W   = 17;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   ch_empty;
  logic [NCH-1:0]   ch_almost_full;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_read_en;
  logic             sram_req;
  logic             sram_ack;
  logic [W-1:0]     sram_wdata;
  logic [1:0]       sram_ch;
  logic             sram_last;
  logic             busy;

  logic [W-1:0]     fq [NCH][$];
  logic [W+2:0]     exp_q [$];
  logic [NCH-1:0]   rd_s;
  int               n_chk = 0;
  int               n_pass = 0;
  int               n_acc = 0;

  fifo_drain_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .ch_empty       (ch_empty),
    .ch_almost_full (ch_almost_full),
    .ch_data        (ch_data),
    .ch_read_en     (ch_read_en),
    .sram_req       (sram_req),
    .sram_ack       (sram_ack),
    .sram_wdata     (sram_wdata),
    .sram_ch        (sram_ch),
    .sram_last      (sram_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(int c, logic [W-1:0] d, bit l);
    fq[c].push_back(d);
    exp_q.push_back({l, 2'(c), d});
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !sram_req; i++) @(negedge clk);
    check("req_seen", sram_req, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++)
      @(negedge clk);
    check("drain", exp_q.size(), 0);
    check("idle", busy, 0);
  endtask

  // FIFO models: registered read data, pop applied at the clock edge
  initial begin
    ch_empty = '1;
    ch_data  = '0;
    rd_s     = '0;
    forever begin
      @(negedge clk);
      rd_s = ch_read_en;
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++)
        if (rd_s[i] && fq[i].size() > 0)
          ch_data[i*W +: W] = fq[i].pop_front();
      #2;
      for (int i = 0; i < NCH; i++)
        ch_empty[i] = (fq[i].size() == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ch_read_en != '0) begin
          check("onehot", $onehot(ch_read_en), 1);
          check("pop_nonempty", |(ch_read_en & ch_empty), 0);
          check("pop_no_req", sram_req, 0);
        end
        if (sram_req && sram_ack) begin
          n_acc++;
          check("sb_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0)
            check("word", {sram_last, sram_ch, sram_wdata}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    logic [1:0]   c;
    int           a0;
    sram_ack       = 1'b0;
    ch_almost_full = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd", ch_read_en, 0);
    check("rst_req", sram_req, 0);
    check("rst_wdata", sram_wdata, 0);
    check("rst_ch", sram_ch, 0);
    check("rst_last", sram_last, 0);
    check("rst_busy", busy, 0);
    #1 rst = 1'b0;

    // single word, latency t+1 / t+3
    sram_ack = 1'b1;
    step();
    push(1, 17'h1ABCD, 1'b1);
    @(negedge clk) check("lat_t0_rd", ch_read_en, 0);
    @(negedge clk) check("lat_t1_rd", ch_read_en, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    check("lat_t3_req", sram_req, 1);
    check("lat_t3_data", sram_wdata, 17'h1ABCD);
    check("lat_t3_ch", sram_ch, 1);
    check("lat_t3_last", sram_last, 1);
    drain();

    // burst limit: 6 words on ch 0 -> 4 + 2
    step();
    for (int j = 0; j < 6; j++)
      push(0, W'($urandom), (j == 3) || (j == 5));
    drain();

    // async reset while a ch 2 word awaits ack
    sram_ack = 1'b0;
    step();
    fq[2].push_back(17'h0F0F0);
    wait_req();
    check("pre_rst_ch", sram_ch, 2);
    #1 rst = 1'b1;
    #1;
    check("arst_req", sram_req, 0);
    check("arst_busy", busy, 0);
    check("arst_rd", ch_read_en, 0);
    step();
    rst = 1'b0;

    // round robin from reset pointer, then wrap-around
    sram_ack = 1'b1;
    step();
    push(0, 17'h00A01, 1'b1);
    push(2, 17'h00A02, 1'b1);
    push(3, 17'h00A03, 1'b1);
    drain();
    step();
    push(0, 17'h10B00, 1'b1);
    push(3, 17'h10B03, 1'b1);
    drain();

    // backpressure on ch 1
    sram_ack = 1'b0;
    step();
    push(1, 17'h15555, 1'b1);
    wait_req();
    w  = sram_wdata;
    c  = sram_ch;
    a0 = n_acc;
    check("bp_ch", c, 1);
    check("bp_data", w, 17'h15555);
    repeat (5) begin
      @(negedge clk);
      check("bp_req", sram_req, 1);
      check("bp_wdata", sram_wdata, w);
      check("bp_chs", sram_ch, c);
      check("bp_rd", ch_read_en, 0);
    end
    step();
    sram_ack = 1'b1;
    step();
    sram_ack = 1'b0;
    drain();
    check("bp_once", n_acc - a0, 1);

    // urgent priority: last grant 0, ch 1 and ch 3 pending, ch 3 almost full
    sram_ack = 1'b1;
    step();
    push(0, 17'h00C00, 1'b1);
    drain();
    step();
    ch_almost_full = 4'b1000;
`ifdef ARB_URGENT_PRIO_EN
    push(3, 17'h00C03, 1'b1);
    push(1, 17'h00C01, 1'b1);
`else
    push(1, 17'h00C01, 1'b1);
    push(3, 17'h00C03, 1'b1);
`endif
    drain();
    ch_almost_full = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
